// File: rtl/accelerator_matrix_integration_pkg.sv
// Shared types and constants for the matrix integration sequencer.
package accelerator_matrix_integration_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StAddWait,
    StMultWait
  } state_e;

  localparam logic [63:0] ZERO_DATA     = 64'h0;
  localparam logic [63:0] ONE_CONTROL   = 64'h1;
  localparam logic        ADD_OPERATION = 1'b0;

endpackage

// File: rtl/accelerator_matrix_integration_counter.sv
// Element (i,j) and sample (k) counters with last-position flags.
module accelerator_matrix_integration_counter #(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 k_inc_i,
  input  logic                 elem_inc_i,
  input  logic [DATA_SIZE-1:0] size_i_i,
  input  logic [DATA_SIZE-1:0] size_j_i,
  input  logic [DATA_SIZE-1:0] length_i,
  output logic                 k_last_o,
  output logic                 j_last_o,
  output logic                 i_last_o
);

  logic [DATA_SIZE-1:0] i_q, i_d;
  logic [DATA_SIZE-1:0] j_q, j_d;
  logic [DATA_SIZE-1:0] k_q, k_d;

  assign k_last_o = (k_q == length_i - DATA_SIZE'(1));
  assign j_last_o = (j_q == size_j_i - DATA_SIZE'(1));
  assign i_last_o = (i_q == size_i_i - DATA_SIZE'(1));

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (elem_inc_i) begin
      k_d = '0;
      if (j_last_o) begin
        j_d = '0;
        i_d = i_q + DATA_SIZE'(1);
      end else begin
        j_d = j_q + DATA_SIZE'(1);
      end
    end else if (k_inc_i) begin
      k_d = k_q + DATA_SIZE'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/accelerator_matrix_integration_controller.sv
// Sequences one float add per sample and one float multiply per element to integrate
// each matrix element over its sample stream (rectangle rule).
module accelerator_matrix_integration_controller
  import accelerator_matrix_integration_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] PERIOD_IN,
  input  logic [DATA_SIZE-1:0] LENGTH_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 ADDER_START,
  output logic                 ADDER_OPERATION,
  output logic [DATA_SIZE-1:0] ADDER_DATA_A_OUT,
  output logic [DATA_SIZE-1:0] ADDER_DATA_B_OUT,
  input  logic                 ADDER_READY,
  input  logic [DATA_SIZE-1:0] ADDER_DATA_IN,
  output logic                 MULT_START,
  output logic [DATA_SIZE-1:0] MULT_DATA_A_OUT,
  output logic [DATA_SIZE-1:0] MULT_DATA_B_OUT,
  input  logic                 MULT_READY,
  input  logic [DATA_SIZE-1:0] MULT_DATA_IN
);

  localparam logic [DATA_SIZE-1:0] Zero = DATA_SIZE'(ZERO_DATA);

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] size_i_q, size_i_d;
  logic [DATA_SIZE-1:0] size_j_q, size_j_d;
  logic [DATA_SIZE-1:0] length_q, length_d;
  logic [DATA_SIZE-1:0] period_q, period_d;
  logic [DATA_SIZE-1:0] acc_q, acc_d;
  logic [DATA_SIZE-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [DATA_SIZE-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 add_start_q, add_start_d;
  logic                 mul_start_q, mul_start_d;
  logic                 ready_q, ready_d;
  logic                 dout_en_q, dout_en_d;
  logic                 cnt_clear, k_inc, elem_inc;
  logic                 k_last, j_last, i_last;

  accelerator_matrix_integration_counter #(
    .DATA_SIZE(DATA_SIZE)
  ) u_counter (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clear_i   (cnt_clear),
    .k_inc_i   (k_inc),
    .elem_inc_i(elem_inc),
    .size_i_i  (size_i_q),
    .size_j_i  (size_j_q),
    .length_i  (length_q),
    .k_last_o  (k_last),
    .j_last_o  (j_last),
    .i_last_o  (i_last)
  );

  always_comb begin
    state_d     = state_q;
    size_i_d    = size_i_q;
    size_j_d    = size_j_q;
    length_d    = length_q;
    period_d    = period_q;
    acc_d       = acc_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    dout_d      = dout_q;
    add_start_d = 1'b0;
    mul_start_d = 1'b0;
    ready_d     = 1'b0;
    dout_en_d   = 1'b0;
    cnt_clear   = 1'b0;
    k_inc       = 1'b0;
    elem_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          size_i_d  = SIZE_I_IN;
          size_j_d  = SIZE_J_IN;
          length_d  = LENGTH_IN;
          period_d  = PERIOD_IN;
          acc_d     = Zero;
          cnt_clear = 1'b1;
          // An empty matrix or empty sample stream completes without any datapath ops.
          if (SIZE_I_IN == '0 || SIZE_J_IN == '0 || LENGTH_IN == '0) begin
            ready_d = 1'b1;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (DATA_IN_ENABLE) begin
          add_a_d     = acc_q;
          add_b_d     = DATA_IN;
          add_start_d = 1'b1;
          state_d     = StAddWait;
        end
      end
      StAddWait: begin
        if (ADDER_READY) begin
          acc_d = ADDER_DATA_IN;
          if (k_last) begin
            mul_a_d     = ADDER_DATA_IN;
            mul_b_d     = period_q;
            mul_start_d = 1'b1;
            state_d     = StMultWait;
          end else begin
            k_inc   = 1'b1;
            state_d = StWaitData;
          end
        end
      end
      StMultWait: begin
        if (MULT_READY) begin
          dout_d    = MULT_DATA_IN;
          dout_en_d = 1'b1;
          acc_d     = Zero;
          elem_inc  = 1'b1;
          if (i_last && j_last) begin
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      size_i_q    <= '0;
      size_j_q    <= '0;
      length_q    <= '0;
      period_q    <= '0;
      acc_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      dout_q      <= '0;
      add_start_q <= 1'b0;
      mul_start_q <= 1'b0;
      ready_q     <= 1'b0;
      dout_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_i_q    <= size_i_d;
      size_j_q    <= size_j_d;
      length_q    <= length_d;
      period_q    <= period_d;
      acc_q       <= acc_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      dout_q      <= dout_d;
      add_start_q <= add_start_d;
      mul_start_q <= mul_start_d;
      ready_q     <= ready_d;
      dout_en_q   <= dout_en_d;
    end
  end

  assign READY            = ready_q;
  assign DATA_OUT_ENABLE  = dout_en_q;
  assign DATA_OUT         = dout_q;
  assign ADDER_START      = add_start_q;
  assign ADDER_OPERATION  = ADD_OPERATION;
  assign ADDER_DATA_A_OUT = add_a_q;
  assign ADDER_DATA_B_OUT = add_b_q;
  assign MULT_START       = mul_start_q;
  assign MULT_DATA_A_OUT  = mul_a_q;
  assign MULT_DATA_B_OUT  = mul_b_q;

endmodule

// File: tb/tb_accelerator_matrix_integration_controller.sv
// Bench for the matrix integration sequencer with behavioural double adder/multiplier.
module tb_accelerator_matrix_integration_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        din_en = 1'b0;
  logic [63:0] size_i_in = '0, size_j_in = '0, period_in = '0, length_in = '0, din = '0;
  logic        ready, dout_en, adder_start, adder_op, mult_start;
  logic [63:0] dout, adder_a, adder_b, mult_a, mult_b;
  logic        adder_ready = 1'b0, mult_ready = 1'b0;
  logic [63:0] adder_dat = '0, mult_dat = '0, add_pend = '0, mult_pend = '0;

  int add_lat = 2, mult_lat = 3, add_cnt = 0, mult_cnt = 0;
  int n_tests = 0, n_fail = 0;
  int out_cnt = 0, ready_cnt = 0, add_start_cnt = 0;
  logic [63:0] sb_q[$];
  real samp_q[$];

  always #5 clk = ~clk;

  accelerator_matrix_integration_controller #(
    .DATA_SIZE(64),
    .CONTROL_SIZE(64)
  ) dut (
    .CLK             (clk),
    .RST             (rst),
    .START           (start),
    .READY           (ready),
    .DATA_IN_ENABLE  (din_en),
    .DATA_OUT_ENABLE (dout_en),
    .SIZE_I_IN       (size_i_in),
    .SIZE_J_IN       (size_j_in),
    .PERIOD_IN       (period_in),
    .LENGTH_IN       (length_in),
    .DATA_IN         (din),
    .DATA_OUT        (dout),
    .ADDER_START     (adder_start),
    .ADDER_OPERATION (adder_op),
    .ADDER_DATA_A_OUT(adder_a),
    .ADDER_DATA_B_OUT(adder_b),
    .ADDER_READY     (adder_ready),
    .ADDER_DATA_IN   (adder_dat),
    .MULT_START      (mult_start),
    .MULT_DATA_A_OUT (mult_a),
    .MULT_DATA_B_OUT (mult_b),
    .MULT_READY      (mult_ready),
    .MULT_DATA_IN    (mult_dat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural double-precision adder and multiplier with programmable latency.
  always @(posedge clk) begin
    adder_ready <= 1'b0;
    if (add_cnt == 1) begin
      adder_ready <= 1'b1;
      adder_dat   <= add_pend;
    end
    if (add_cnt > 0) add_cnt <= add_cnt - 1;
    if (adder_start) begin
      add_pend <= $realtobits($bitstoreal(adder_a) + $bitstoreal(adder_b));
      add_cnt  <= add_lat;
    end
  end

  always @(posedge clk) begin
    mult_ready <= 1'b0;
    if (mult_cnt == 1) begin
      mult_ready <= 1'b1;
      mult_dat   <= mult_pend;
    end
    if (mult_cnt > 0) mult_cnt <= mult_cnt - 1;
    if (mult_start) begin
      mult_pend <= $realtobits($bitstoreal(mult_a) * $bitstoreal(mult_b));
      mult_cnt  <= mult_lat;
    end
  end

  always @(negedge clk) begin
    if (dout_en) begin
      out_cnt++;
      if (sb_q.size() == 0) check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
      else check_eq("data_out", dout, sb_q.pop_front());
    end
    if (ready) ready_cnt++;
    if (adder_start) add_start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int si, input int sj, input int len, input real period,
                         input bit start_in_mult, input bit inject7);
    real acc, x;
    bit  got;
    size_i_in = 64'(si);
    size_j_in = 64'(sj);
    length_in = 64'(len);
    period_in = $realtobits(period);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < si * sj; e++) begin
      acc = 0.0;
      for (int k = 0; k < len; k++) begin
        x = samp_q.pop_front();
        din = $realtobits(x);
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
        check_eq("adder_start", 64'(adder_start), 64'd1);
        if (inject7) begin
          din = $realtobits(7.0);
          din_en = 1'b1;
          tick();
          din_en = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
          if (adder_ready) begin
            got = 1'b1;
            break;
          end
          check_eq("hold_add_a", adder_a, $realtobits(acc));
          check_eq("hold_add_b", adder_b, $realtobits(x));
          tick();
        end
        check_eq("adder_ready_seen", 64'(got), 64'd1);
        acc = acc + x;
        if (k == len - 1) sb_q.push_back($realtobits(acc * period));
        tick();
      end
      if (start_in_mult) begin
        size_j_in = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        size_j_in = 64'(sj);
      end
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (dout_en) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      check_eq("out_seen", 64'(got), 64'd1);
      check_eq("mult_b_period", mult_b, $realtobits(period));
      check_eq("ready_with_last", 64'(ready), 64'(e == si * sj - 1));
      tick();
    end
  endtask

  initial begin
    int o0, r0, a0;
    repeat (3) tick();
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_dout_en", 64'(dout_en), 64'd0);
    check_eq("rst_dout", dout, 64'd0);
    check_eq("rst_add_start", 64'(adder_start), 64'd0);
    check_eq("rst_mult_start", 64'(mult_start), 64'd0);
    check_eq("rst_add_a", adder_a, 64'd0);
    check_eq("rst_mult_b", mult_b, 64'd0);
    check_eq("rst_add_op", 64'(adder_op), 64'd0);
    rst = 1'b0;
    tick();

    // 1x1, four samples of 1.0, period 0.5
    o0 = out_cnt; r0 = ready_cnt; a0 = add_start_cnt;
    repeat (4) samp_q.push_back(1.0);
    run_job(1, 1, 4, 0.5, 1'b0, 1'b0);
    repeat (5) tick();
    check_eq("a_outs", 64'(out_cnt - o0), 64'd1);
    check_eq("a_ready", 64'(ready_cnt - r0), 64'd1);
    check_eq("a_adds", 64'(add_start_cnt - a0), 64'd4);
    check_eq("a_dout_hold", dout, 64'h4000000000000000);
    check_eq("a_dout_en_low", 64'(dout_en), 64'd0);

    // 2x2, element e gets samples {e,e}
    o0 = out_cnt; r0 = ready_cnt;
    for (int e = 0; e < 4; e++) begin
      samp_q.push_back(real'(e));
      samp_q.push_back(real'(e));
    end
    run_job(2, 2, 2, 1.0, 1'b0, 1'b0);
    repeat (3) tick();
    check_eq("b_outs", 64'(out_cnt - o0), 64'd4);
    check_eq("b_ready", 64'(ready_cnt - r0), 64'd1);
    check_eq("b_last", dout, 64'h4018000000000000);

    // Zero columns: immediate READY, no datapath activity
    o0 = out_cnt; r0 = ready_cnt; a0 = add_start_cnt;
    size_i_in = 64'd1; size_j_in = 64'd0; length_in = 64'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("c_ready_pulse", 64'(ready), 64'd1);
    tick();
    check_eq("c_ready_low", 64'(ready), 64'd0);
    repeat (5) tick();
    check_eq("c_outs", 64'(out_cnt - o0), 64'd0);
    check_eq("c_adds", 64'(add_start_cnt - a0), 64'd0);
    check_eq("c_ready", 64'(ready_cnt - r0), 64'd1);

    // DATA_IN_ENABLE with 7.0 during ADD_WAIT is ignored
    o0 = out_cnt; a0 = add_start_cnt;
    samp_q.push_back(3.0);
    run_job(1, 1, 1, 1.0, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("d_outs", 64'(out_cnt - o0), 64'd1);
    check_eq("d_adds", 64'(add_start_cnt - a0), 64'd1);
    check_eq("d_dout", dout, 64'h4008000000000000);

    // START during MULT_WAIT has no effect
    o0 = out_cnt; r0 = ready_cnt; a0 = add_start_cnt;
    samp_q.push_back(2.0);
    run_job(1, 1, 1, 1.0, 1'b1, 1'b0);
    repeat (5) tick();
    check_eq("e_outs", 64'(out_cnt - o0), 64'd1);
    check_eq("e_ready", 64'(ready_cnt - r0), 64'd1);
    check_eq("e_adds", 64'(add_start_cnt - a0), 64'd1);

    // RST while in ADD_WAIT
    add_lat = 6;
    o0 = out_cnt; r0 = ready_cnt;
    size_i_in = 64'd1; size_j_in = 64'd1; length_in = 64'd2; period_in = $realtobits(1.0);
    start = 1'b1;
    tick();
    start = 1'b0;
    din = $realtobits(1.0);
    din_en = 1'b1;
    tick();
    din_en = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("f_add_a", adder_a, 64'd0);
    check_eq("f_add_b", adder_b, 64'd0);
    check_eq("f_dout", dout, 64'd0);
    check_eq("f_mult_b", mult_b, 64'd0);
    check_eq("f_add_start", 64'(adder_start), 64'd0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check_eq("f_outs", 64'(out_cnt - o0), 64'd0);
    check_eq("f_ready", 64'(ready_cnt - r0), 64'd0);
    add_lat = 2;

    // Restart after reset
    o0 = out_cnt; r0 = ready_cnt;
    samp_q.push_back(1.5);
    samp_q.push_back(2.5);
    run_job(1, 2, 1, 2.0, 1'b0, 1'b0);
    repeat (3) tick();
    check_eq("g_outs", 64'(out_cnt - o0), 64'd2);
    check_eq("g_ready", 64'(ready_cnt - r0), 64'd1);

    // Adder stalled 20 cycles: operands held, single START per sample
    add_lat = 20;
    o0 = out_cnt; a0 = add_start_cnt;
    samp_q.push_back(1.0);
    samp_q.push_back(2.0);
    run_job(1, 1, 2, 0.5, 1'b0, 1'b0);
    repeat (3) tick();
    check_eq("h_outs", 64'(out_cnt - o0), 64'd1);
    check_eq("h_adds", 64'(add_start_cnt - a0), 64'd2);
    check_eq("h_dout", dout, 64'h3FF8000000000000);

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
